// File: rtl/keypad_responder_pkg.sv
// Shared definitions for the keypad responder: FSM state encoding, matrix
// geometry, the active-low idle pattern and the key-index split used by the
// keypad scanner (row = key[3:2], column = key[1:0]).
package keypad_responder_pkg;

   localparam int ROWS  = 4;
   localparam int COLS  = 4;
   localparam int KEY_W = 4;
   localparam int SEL_W = 2;

   localparam logic [COLS-1:0] COLS_IDLE = 4'b1111;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_BOUNCE_IN  = 3'd1,
      ST_HOLD       = 3'd2,
      ST_BOUNCE_OUT = 3'd3,
      ST_GAP        = 3'd4
   } state_e;

   function automatic logic [SEL_W-1:0] key_row(input logic [KEY_W-1:0] key);
      return key[3:2];
   endfunction

   function automatic logic [SEL_W-1:0] key_col(input logic [KEY_W-1:0] key);
      return key[1:0];
   endfunction

endpackage

// File: rtl/keypad_col_drive.sv
// Column sense driver for an emulated keypad key.
// Pulls the latched key's column low on the cycle after its row strobe is
// seen low while the contact is closed; otherwise all columns idle high.
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (columns return to idle)
//   contact_i  emulated contact state, 1 = closed
//   key_i      latched key index (row = [3:2], column = [1:0])
//   fila_i     active-low row strobes from the scanner
//   columna_o  active-low registered column sense lines
module keypad_col_drive
   import keypad_responder_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             contact_i,
   input  logic [KEY_W-1:0] key_i,
   input  logic [ROWS-1:0]  fila_i,
   output logic [COLS-1:0]  columna_o
);

   logic [COLS-1:0] columna_d;
   logic [COLS-1:0] columna_q;

   // Any number of rows may be strobed at once; only the latched row matters,
   // exactly as a single closed switch in a real matrix would behave.
   always_comb begin
      columna_d = COLS_IDLE;
      if (contact_i && !fila_i[key_row(key_i)]) begin
         columna_d[key_col(key_i)] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         columna_q <= COLS_IDLE;
      end else begin
         columna_q <= columna_d;
      end
   end

   assign columna_o = columna_q;

endmodule

// File: rtl/keypad_responder.sv
// Keypad matrix responder: emulates one key press at a time on a 4x4
// row-scan/column-sense keypad, with make/break bounce, hold time and a
// release gap before the next request is taken.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | contact open, press_ready high, waiting for press_valid
// BOUNCE_IN  | contact chatters (counter bit 0) for BOUNCE_CYCLES cycles
// HOLD       | contact solidly closed for HOLD_CYCLES cycles
// BOUNCE_OUT | contact chatters again for BOUNCE_CYCLES cycles
// GAP        | contact open for GAP_CYCLES cycles, then done pulse
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   fila         active-low row strobes from the scanner
//   columna      active-low column sense lines (idle 4'b1111)
//   press_key    key to press: row = [3:2], column = [1:0]
//   press_valid  press request
//   press_ready  high only while idle
//   busy         high whenever not idle
//   done         one-cycle pulse when the release gap completes
//   contact      current emulated contact state (debug)
module keypad_responder
   import keypad_responder_pkg::*;
#(
   parameter int HOLD_CYCLES   = 5_000_000,
   parameter int BOUNCE_CYCLES = 50_000,
   parameter int GAP_CYCLES    = 2_500_000,
   parameter int CNT_W         = 24
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [ROWS-1:0]  fila,
   output logic [COLS-1:0]  columna,
   input  logic [KEY_W-1:0] press_key,
   input  logic             press_valid,
   output logic             press_ready,
   output logic             busy,
   output logic             done,
   output logic             contact
);

   localparam bit NO_BOUNCE = (BOUNCE_CYCLES == 0);

   // Terminal counts; the bounce value is unused when bounce is disabled.
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] BOUNCE_LAST =
      CNT_W'((BOUNCE_CYCLES > 0) ? BOUNCE_CYCLES - 1 : 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             done_q, done_d;
   logic             contact_s;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         key_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         key_q   <= key_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; the counter restarts from zero on every state entry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      key_d   = key_q;
      done_d  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (press_valid) begin
               key_d   = press_key;
               state_d = NO_BOUNCE ? ST_HOLD : ST_BOUNCE_IN;
            end
         end
         ST_BOUNCE_IN: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d = ST_HOLD;
               cnt_d   = '0;
            end
         end
         ST_HOLD: begin
            if (cnt_q == HOLD_LAST) begin
               state_d = NO_BOUNCE ? ST_GAP : ST_BOUNCE_OUT;
               cnt_d   = '0;
            end
         end
         ST_BOUNCE_OUT: begin
            if (cnt_q == BOUNCE_LAST) begin
               state_d = ST_GAP;
               cnt_d   = '0;
            end
         end
         ST_GAP: begin
            if (cnt_q == GAP_LAST) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Output decode
   always_comb begin
      contact_s   = 1'b0;
      press_ready = 1'b0;
      busy        = 1'b1;
      unique case (state_q)
         ST_IDLE: begin
            press_ready = 1'b1;
            busy        = 1'b0;
         end
         ST_BOUNCE_IN,
         ST_BOUNCE_OUT: contact_s = cnt_q[0];
         ST_HOLD:       contact_s = 1'b1;
         default:       contact_s = 1'b0;
      endcase
   end

   assign contact = contact_s;
   assign done    = done_q;

   keypad_col_drive u_col_drive (
      .clk       (clk),
      .rst       (rst),
      .contact_i (contact_s),
      .key_i     (key_q),
      .fila_i    (fila),
      .columna_o (columna)
   );

endmodule
